// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
package regfile_wb_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NREG       = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Writeback requester identities, also the encoding of the round-robin pointer.
    typedef enum logic {
        WB_EX  = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the EX and MEM writeback requesters.
module rr_arb2
    import regfile_wb_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ex,
    input  logic req_mem,
    output logic gnt_ex,
    output logic gnt_mem
);

    wb_src_e r_rr_ptr;

    // Grant a lone requester directly; on contention grant the one rr_ptr names.
    always_comb begin
        gnt_ex  = 1'b0;
        gnt_mem = 1'b0;
        if (!reset) begin
            if (req_ex && req_mem) begin
                if (r_rr_ptr == WB_EX) gnt_ex  = 1'b1;
                else                   gnt_mem = 1'b1;
            end else begin
                gnt_ex  = req_ex;
                gnt_mem = req_mem;
            end
        end
    end

    // Pointer flips only on contention, so a lone grant leaves priority untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= WB_EX;
        end else if (req_ex && req_mem) begin
            r_rr_ptr <= (r_rr_ptr == WB_EX) ? WB_MEM : WB_EX;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file write-port controller: arbitrates EX/MEM writebacks onto the
// single registered write port and keeps a per-register pending-write scoreboard.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_wb_valid,
    output logic                  ex_wb_ready,
    input  logic [REG_ADDR_W-1:0] ex_wb_addr,
    input  logic [REG_DATA_W-1:0] ex_wb_data,
    input  logic                  mem_wb_valid,
    output logic                  mem_wb_ready,
    input  logic [REG_ADDR_W-1:0] mem_wb_addr,
    input  logic [REG_DATA_W-1:0] mem_wb_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [REG_DATA_W-1:0] rf_wdata,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic                  rd_busy1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  rd_busy2,
    output logic                  sb_err
);

    logic                  w_gnt_ex;
    logic                  w_gnt_mem;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [REG_DATA_W-1:0] w_sel_data;
    logic                  w_wr;
    logic [NREG-1:0]       w_inc;
    logic [NREG-1:0]       w_dec;
    logic                  w_dec_err;

    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [REG_DATA_W-1:0] r_rf_wdata;
    logic                  r_sb_err;
    logic [CNT_W-1:0]      r_cnt [NREG];

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_ex  (ex_wb_valid),
        .req_mem (mem_wb_valid),
        .gnt_ex  (w_gnt_ex),
        .gnt_mem (w_gnt_mem)
    );

    assign ex_wb_ready  = w_gnt_ex;
    assign mem_wb_ready = w_gnt_mem;

    // Mux the granted request; writes to r0 are accepted but never reach the port.
    always_comb begin
        w_sel_addr = w_gnt_mem ? mem_wb_addr : ex_wb_addr;
        w_sel_data = w_gnt_mem ? mem_wb_data : ex_wb_data;
        w_wr       = (w_gnt_ex || w_gnt_mem) && (w_sel_addr != ZERO_REG);
    end

    // Registered write port; address/data hold when no write is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_wr;
            if (w_wr) begin
                r_rf_waddr <= w_sel_addr;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    assign iss_ready = !reset &&
                       ((iss_dest == ZERO_REG) || (r_cnt[iss_dest] != '1));

    // Per-register increment on accepted issue, decrement on the committing write.
    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_dec_err = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            w_inc[r] = iss_valid && iss_ready && (iss_dest == REG_ADDR_W'(r));
            w_dec[r] = r_rf_we && (r_rf_waddr == REG_ADDR_W'(r));
            if (w_dec[r] && (r_cnt[r] == '0)) w_dec_err = 1'b1;
        end
    end

    // Scoreboard counters; an underflowing decrement clamps at 0 and flags sb_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                end else if (!w_inc[r] && w_dec[r] && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
            if (w_dec_err) r_sb_err <= 1'b1;
        end
    end

    assign sb_err   = r_sb_err;
    assign rd_busy1 = (rd_addr1 != ZERO_REG) && (r_cnt[rd_addr1] != '0);
    assign rd_busy2 = (rd_addr2 != ZERO_REG) && (r_cnt[rd_addr2] != '0);

endmodule
